pc_flow_ctrl: RTL and testbench

Fetch-side pipeline flow controller: consumes hazard-unit requests (load-use hold, late-jump hold, jump redirect) and turns them into PC sequencing, IF/ID stall/flush, and ID/EX bubble insertion. Sits between the hazard detector and the IF stage, owning the architectural fetch PC and the instruction-memory fetch handshake. Every stall and flush in the core is sequenced here.

---
 rtl/pc_flow_ctrl_pkg.sv | 15 +
 rtl/pc_flow_perf.sv | 32 +++
 rtl/pc_flow_ctrl.sv | 111 +++++++++++
 tb/tb_pc_flow_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_flow_ctrl_pkg.sv
// Shared definitions for the fetch-side flow controller: sequencing states,
// PC increment and the NOP encoding loaded into IF/ID and ID/EX on flush/bubble.
package pc_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } pc_state_e;

  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pc_flow_perf.sv
// Saturating event counters for stall, flush and bubble cycles.
// Only instantiated when PC_FLOW_PERF_EN is defined.
module pc_flow_perf
  import pc_flow_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        bubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] bubble_cnt
);

  // Each counter advances once per cycle its event is high and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
      if (bubble && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Fetch PC sequencer: turns hazard-unit requests (load-use hold, late-jump
// hold, jump redirect) into PC updates and IF/ID stall/flush and ID/EX bubble.
// Optional feature macro: PC_FLOW_PERF_EN adds saturating event counters.
module pc_flow_ctrl
  import pc_flow_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_hold,
  input  logic              jmp_hold,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic              imem_req,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_bubble
`ifdef PC_FLOW_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        fcnt_q, fcnt_d;

  // State, PC and flush counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Priority: jmp > flush in progress > stall follow-up > ld_hold > jmp_hold/imem wait > advance.
  // The flush and stall-follow-up branches sit above ld_hold so hazards are ignored
  // while flushing and a held ld_hold yields only one bubble per STALL visit.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fcnt_d       = fcnt_q;
    imem_req     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      default: begin
        imem_req = 1'b1;
        if (jmp) begin
          pc_d        = jmp_addr_i & ALIGN_MASK;
          if_id_flush = 1'b1;
          fcnt_d      = FLUSH_INIT;
          state_d     = (FLUSH_INIT != '0) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
          if_id_flush = 1'b1;
          if (imem_ready)
            pc_d = pc_q + STEP;
          fcnt_d  = (fcnt_q != '0) ? (fcnt_q - 4'd1) : '0;
          state_d = (fcnt_d == '0) ? RUN : FLUSH;
        end else if (state_q == STALL) begin
          if_id_stall = 1'b1;
          state_d     = RUN;
        end else if (ld_hold) begin
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = STALL;
        end else if (jmp_hold || !imem_ready) begin
          if_id_stall = 1'b1;
        end else begin
          pc_d = pc_q + STEP;
        end
      end
    endcase
  end

  assign pc_o = pc_q;

`ifdef PC_FLOW_PERF_EN
  pc_flow_perf u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (if_id_stall),
    .flush      (if_id_flush),
    .bubble     (id_ex_bubble),
    .stall_cnt  (stall_cnt_o),
    .flush_cnt  (flush_cnt_o),
    .bubble_cnt (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl with a cycle-level behavioural model.
module tb_pc_flow_ctrl;

  localparam int unsigned FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_hold = 1'b0;
  logic        jmp_hold = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_addr_i = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc_o;
  logic        imem_req;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_bubble;
`ifdef PC_FLOW_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [31:0] bubble_cnt_o;
`endif

  pc_flow_ctrl #(
    .ADDR_W       (32),
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_hold      (ld_hold),
    .jmp_hold     (jmp_hold),
    .jmp          (jmp),
    .jmp_addr_i   (jmp_addr_i),
    .imem_ready   (imem_ready),
    .pc_o         (pc_o),
    .imem_req     (imem_req),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble)
`ifdef PC_FLOW_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: current cycle (m_*) and what it becomes after the next edge (n_*).
  bit          m_boot, n_boot;
  logic [31:0] m_pc, n_pc;
  int          m_flush_left, n_flush_left;
  bit          m_after_bubble, n_after_bubble;
  logic [31:0] exp_pc;
  bit          exp_req, exp_stall, exp_flush, exp_bubble;
  longint      cnt_stall, cnt_flush, cnt_bubble;

  task automatic model_reset();
    m_boot = 1'b1; n_boot = 1'b1;
    m_pc = 32'h0; n_pc = 32'h0;
    m_flush_left = 0; n_flush_left = 0;
    m_after_bubble = 1'b0; n_after_bubble = 1'b0;
    exp_pc = 32'h0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_flush = 1'b0; exp_bubble = 1'b0;
    cnt_stall = 0; cnt_flush = 0; cnt_bubble = 0;
  endtask

  // Drive one cycle of inputs and compute what the controller should show.
  task automatic apply(input bit j, input logic [31:0] a, input bit ld, input bit jh, input bit rdy);
    @(negedge clk);
    cnt_stall  += exp_stall;
    cnt_flush  += exp_flush;
    cnt_bubble += exp_bubble;
    m_boot = n_boot;
    m_pc = n_pc;
    m_flush_left = n_flush_left;
    m_after_bubble = n_after_bubble;
    jmp = j; jmp_addr_i = a; ld_hold = ld; jmp_hold = jh; imem_ready = rdy;
    exp_pc = m_pc;
    exp_req = 1'b0; exp_stall = 1'b0; exp_flush = 1'b0; exp_bubble = 1'b0;
    n_boot = m_boot; n_pc = m_pc; n_flush_left = m_flush_left; n_after_bubble = m_after_bubble;
    if (m_boot) begin
      n_boot = 1'b0;
    end else begin
      exp_req = 1'b1;
      if (j) begin
        exp_flush = 1'b1;
        n_pc = {a[31:2], 2'b00};
        n_flush_left = FLUSH_N - 1;
        n_after_bubble = 1'b0;
      end else if (m_flush_left > 0) begin
        exp_flush = 1'b1;
        if (rdy) n_pc = m_pc + 32'd4;
        n_flush_left = m_flush_left - 1;
      end else if (m_after_bubble) begin
        exp_stall = 1'b1;
        n_after_bubble = 1'b0;
      end else if (ld) begin
        exp_stall = 1'b1;
        exp_bubble = 1'b1;
        n_after_bubble = 1'b1;
      end else if (jh || !rdy) begin
        exp_stall = 1'b1;
      end else begin
        n_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jmp = 1'b0; ld_hold = 1'b0; jmp_hold = 1'b0; imem_ready = 1'b0; jmp_addr_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] want_pc [3];
    want_pc[0] = 32'h0; want_pc[1] = 32'h4; want_pc[2] = 32'h8;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble} !== {32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_hold: pc=%h req=%b stall=%b flush=%b bubble=%b want pc=0 all 0",
               pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply(0, 32'h0, 0, 0, 1);
    total++;
    if ({pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble} !== {32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL boot_cycle: pc=%h req=%b stall=%b flush=%b bubble=%b want pc=0 all 0",
               pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 32'h0, 0, 0, 1);
      total++;
      if (pc_o !== want_pc[i] || imem_req !== 1'b1) begin
        bad++;
        $display("FAIL reset_seq[%0d]: pc=%h req=%b want pc=%h req=1", i, pc_o, imem_req, want_pc[i]);
      end
    end
  endtask

  task automatic test_jump();
    int flushes;
    logic [31:0] seen [3];
    apply(1, 32'h0000_0103, 0, 0, 1);
    flushes = int'(if_id_flush);
    total++;
    if (if_id_flush !== 1'b1 || if_id_stall !== 1'b0) begin
      bad++;
      $display("FAIL jump_cycle: flush=%b stall=%b want flush=1 stall=0", if_id_flush, if_id_stall);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 32'h0, 0, 0, 1);
      flushes += int'(if_id_flush);
      seen[i] = pc_o;
      total++;
      if ({pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble} !==
          {exp_pc, exp_req, exp_stall, exp_flush, exp_bubble}) begin
        bad++;
        $display("FAIL jump_model[%0d]: pc=%h s=%b f=%b b=%b want pc=%h s=%b f=%b b=%b", i,
                 pc_o, if_id_stall, if_id_flush, id_ex_bubble, exp_pc, exp_stall, exp_flush, exp_bubble);
      end
    end
    total++;
    if (flushes !== 2 || seen[0] !== 32'h100 || seen[1] !== 32'h104 || seen[2] !== 32'h108) begin
      bad++;
      $display("FAIL jump_target: flush_cycles=%0d pcs=%h %h %h want 2 and 100 104 108",
               flushes, seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_load_use();
    int bubbles = 0;
    int stalls = 0;
    logic [31:0] seen [4];
    apply(1, 32'h0000_001C, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply(0, 32'h0, (i < 2), 0, 1);
      bubbles += int'(id_ex_bubble);
      stalls  += int'(if_id_stall);
      seen[i] = pc_o;
      total++;
      if ({pc_o, if_id_stall, if_id_flush, id_ex_bubble} !== {exp_pc, exp_stall, exp_flush, exp_bubble}) begin
        bad++;
        $display("FAIL load_use_model[%0d]: pc=%h s=%b f=%b b=%b want pc=%h s=%b f=%b b=%b", i,
                 pc_o, if_id_stall, if_id_flush, id_ex_bubble, exp_pc, exp_stall, exp_flush, exp_bubble);
      end
    end
    total++;
    if (bubbles !== 1 || stalls !== 2 || seen[0] !== 32'h20 || seen[1] !== 32'h20 ||
        seen[2] !== 32'h20 || seen[3] !== 32'h24) begin
      bad++;
      $display("FAIL load_use: bubbles=%0d stalls=%0d pcs=%h %h %h %h want 1 2 20 20 20 24",
               bubbles, stalls, seen[0], seen[1], seen[2], seen[3]);
    end
  endtask

  task automatic test_jmp_and_ld();
    apply(1, 32'h0000_0200, 1, 1, 1);
    total++;
    if ({if_id_stall, if_id_flush, id_ex_bubble} !== 3'b010) begin
      bad++;
      $display("FAIL jmp_ld_same: stall=%b flush=%b bubble=%b want 0 1 0", if_id_stall, if_id_flush, id_ex_bubble);
    end
    apply(0, 32'h0, 1, 1, 1);
    total++;
    if (pc_o !== 32'h200 || if_id_flush !== 1'b1 || if_id_stall !== 1'b0 || id_ex_bubble !== 1'b0) begin
      bad++;
      $display("FAIL flush_ignores_hold: pc=%h s=%b f=%b b=%b want 200 0 1 0",
               pc_o, if_id_stall, if_id_flush, id_ex_bubble);
    end
    apply(0, 32'h0, 0, 0, 1);
  endtask

  task automatic test_imem_wait();
    apply(1, 32'h0000_003C, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 32'h0, 0, 0, 0);
      total++;
      if (pc_o !== 32'h40 || if_id_stall !== 1'b1 || id_ex_bubble !== 1'b0 || if_id_flush !== 1'b0) begin
        bad++;
        $display("FAIL imem_wait[%0d]: pc=%h s=%b f=%b b=%b want 40 1 0 0", i,
                 pc_o, if_id_stall, if_id_flush, id_ex_bubble);
      end
    end
    apply(0, 32'h0, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    total++;
    if (pc_o !== 32'h44) begin
      bad++;
      $display("FAIL imem_resume: pc=%h want 44", pc_o);
    end
    apply(1, 32'hFFFF_FFF8, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    total++;
    if (pc_o !== 32'hFFFF_FFFC || if_id_flush !== 1'b0) begin
      bad++;
      $display("FAIL wrap_pre: pc=%h flush=%b want fffffffc 0", pc_o, if_id_flush);
    end
    apply(0, 32'h0, 0, 0, 1);
    total++;
    if (pc_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap: pc=%h want 00000000", pc_o);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 12) == 0, $urandom, ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 4) != 0);
      total++;
      if ({pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble} !==
          {exp_pc, exp_req, exp_stall, exp_flush, exp_bubble} || (if_id_stall && if_id_flush)) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random[%0d]: pc=%h r=%b s=%b f=%b b=%b want pc=%h r=%b s=%b f=%b b=%b", i,
                   pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble,
                   exp_pc, exp_req, exp_stall, exp_flush, exp_bubble);
      end
    end
`ifdef PC_FLOW_PERF_EN
    total++;
    if (stall_cnt_o !== 32'(cnt_stall) || flush_cnt_o !== 32'(cnt_flush) || bubble_cnt_o !== 32'(cnt_bubble)) begin
      bad++;
      $display("FAIL perf_counts: stall=%0d flush=%0d bubble=%0d want %0d %0d %0d",
               stall_cnt_o, flush_cnt_o, bubble_cnt_o, cnt_stall, cnt_flush, cnt_bubble);
    end
`endif
  endtask

  task automatic test_async_reset();
    apply(1, 32'h0000_0500, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble} !== {32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_mid_flush: pc=%h r=%b s=%b f=%b b=%b want 0 0 0 0 0",
               pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble);
    end
`ifdef PC_FLOW_PERF_EN
    total++;
    if (stall_cnt_o !== 32'h0 || flush_cnt_o !== 32'h0 || bubble_cnt_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_perf: stall=%0d flush=%0d bubble=%0d want 0 0 0",
               stall_cnt_o, flush_cnt_o, bubble_cnt_o);
    end
`endif
    do_reset();
    apply(0, 32'h0, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    apply(0, 32'h0, 1, 0, 1);
    apply(0, 32'h0, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble} !== {32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_mid_stall: pc=%h r=%b s=%b f=%b b=%b want 0 0 0 0 0",
               pc_o, imem_req, if_id_stall, if_id_flush, id_ex_bubble);
    end
    do_reset();
    apply(0, 32'h0, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    apply(0, 32'h0, 0, 0, 1);
    total++;
    if (pc_o !== 32'h4 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: pc=%h req=%b want 4 1", pc_o, imem_req);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_jump();
    test_load_use();
    test_jmp_and_ld();
    test_imem_wait();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
